pulse_analyzer: RTL and testbench
=================================

# pulse_analyzer

Consumer at the far end of the signal chain. It takes the sample stream produced by one `vN_filter` instance, which is itself driven by `exp_sig_gen`. It detects each pulse that crosses a programmable threshold and measures the pulse's peak amplitude, peak timestamp and width above threshold. It flags pile-up and emits one result record per pulse with a single-cycle valid strobe.

## Interface
- `DATA_WIDTH`, default `SIZE_FILTER_DATA` (package_settings): sample width, signed two's complement.
- `TIME_WIDTH`, default 16: timestamp counter width.
- `WIDTH_BITS`, default 8: pulse-width counter width.
- `HOLDOFF`, default 8: dead-time cycles after each pulse (≥1).
- `PILEUP_DELTA`, default 4: re-rise margin for pile-up detection.
- `clk`  in  1  system clock; the single clock domain.
- `reset`  in  1  synchronous, active-high.
- `input_data`  in  DATA_WIDTH  filter output sample, one per clock, signed.
- `threshold`  in  DATA_WIDTH  signed trigger level; must be held stable during a pulse.
- `output_valid`  out  1  one-cycle strobe; the record below is valid in that cycle.
- `peak_amplitude`  out  DATA_WIDTH  maximum sample of the pulse.
- `peak_time`  out  TIME_WIDTH  timestamp of the first maximum sample.
- `pulse_width`  out  WIDTH_BITS  count of samples strictly above threshold, saturating.
- `pile_up`  out  1  second rise detected within the pulse.
- `busy`  out  1  FSM not in IDLE.

## Operation
- Timestamp counter `ts`:
  - Free-running, 0 after reset, +1 per clock, wraps modulo 2^TIME_WIDTH.
  - The timestamp of a sample is the `ts` value in the cycle that sample is on `input_data`.
- Stage 0 registers `x` = `input_data` and its timestamp. The FSM evaluates `x` one cycle later, keeping `prev` = the previous `x`.
- All comparisons are signed.
  - `prev + PILEUP_DELTA` is computed at DATA_WIDTH+1 bits with sign extension, so there is no overflow.
- FSM states:
  - IDLE:
    - If `x > threshold`: peak←x, peak_time←ts(x), width←1, pile←0, go RISE.
  - RISE:
    - If `x ≤ threshold`: emit, go HOLDOFF.
    - Else width+1 (saturating at all-ones).
    - If `x > peak`: update peak and peak_time. Ties keep the earlier sample.
    - If `x < prev`: go FALL.
  - FALL:
    - If `x ≤ threshold`: emit, go HOLDOFF.
    - Else width+1.
    - If `x > prev + PILEUP_DELTA`: pile←1, go RISE.
    - Peak tracking continues in FALL under the same rule.
  - HOLDOFF:
    - Counts HOLDOFF cycles, ignoring input, then goes to IDLE.
    - A sample still above threshold when IDLE is re-entered starts a new pulse.
- Emit:
  - Registers the record onto the outputs and pulses `output_valid` for one cycle.
  - Outputs hold their value until the next emit.
- Timestamp wrap within a pulse is ignored.
- Reset mid-pulse: FSM goes to IDLE, the partial pulse is discarded, and no `output_valid` is produced.

## Timing
- Reset values: `output_valid`=0, `peak_amplitude`=0, `peak_time`=0, `pulse_width`=0, `pile_up`=0, `busy`=0, `ts`=0.
- Latency: `output_valid` is asserted 2 cycles after the first sample ≤ threshold appears on `input_data`.
  - Sample in cycle n → registered end of n → FSM decides in n+1 → outputs visible in n+2.
- `busy` rises 2 cycles after the first above-threshold sample. It falls when the HOLDOFF count completes.
- Minimum spacing between `output_valid` strobes: HOLDOFF+2 cycles.
- No back-pressure. The downstream must accept the record in its strobe cycle.

## Test plan
- Single pulse: threshold=100; samples 0,50,150,300,250,120,80,0 at ts 0..7.
  - Expect `output_valid` in the cycle ts=8: peak_amplitude=300, peak_time=3, pulse_width=4, pile_up=0.
- Pile-up: threshold=100, PILEUP_DELTA=4; samples 0,150,300,200,260,120,50.
  - Expect peak=300, peak_time=2, width=5, pile_up=1.
  - Variant with 200→203 instead of 260: expect pile_up=0.
- Tie and holdoff: samples 0,150,300,300,90, then 200,90 starting 2 cycles later (inside HOLDOFF=8).
  - Expect exactly one record: peak_time=2, width=3. The second pulse is ignored.
- Reset mid-pulse: assert `reset` for 1 cycle during the 300 sample of the single-pulse stream.
  - Expect no `output_valid`, `busy`=0 the cycle after reset, and all outputs 0.
- Width saturation: WIDTH_BITS=8; 300 consecutive samples of 500, then 0.
  - Expect pulse_width=255 and peak_time equal to the first sample's timestamp.
- Negative samples and timestamp wrap: threshold=-10; pulse straddles ts 65535→0; samples -50,-5,20,-5,-50.
  - Expect peak_amplitude=20 and a correct wrapped peak_time.

Source files
------------

// File: rtl/pulse_analyzer.sv
// Threshold-triggered pulse analyzer: measures peak amplitude, peak time, width above threshold
// and pile-up for each pulse, then emits one registered record per pulse.
module pulse_analyzer #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned TIME_WIDTH   = 16,
  parameter int unsigned WIDTH_BITS   = 8,
  parameter int unsigned HOLDOFF      = 8,
  parameter int unsigned PILEUP_DELTA = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] input_data,
  input  logic [DATA_WIDTH-1:0] threshold,
  output logic                  output_valid,
  output logic [DATA_WIDTH-1:0] peak_amplitude,
  output logic [TIME_WIDTH-1:0] peak_time,
  output logic [WIDTH_BITS-1:0] pulse_width,
  output logic                  pile_up,
  output logic                  busy
);

  localparam int unsigned HoldW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic signed [DATA_WIDTH:0] DeltaW = (DATA_WIDTH + 1)'(PILEUP_DELTA);

  typedef enum logic [1:0] {StIdle, StRise, StFall, StHold} state_e;

  state_e                state_q;
  logic [TIME_WIDTH-1:0] ts_q;
  logic [TIME_WIDTH-1:0] x_ts_q;
  logic [TIME_WIDTH-1:0] peak_time_q;
  logic [DATA_WIDTH-1:0] x_q;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] peak_q;
  logic                  x_vld_q;
  logic [WIDTH_BITS-1:0] width_q;
  logic                  pile_q;
  logic [HoldW-1:0]      hold_q;

  logic                         above;
  logic                         new_peak;
  logic                         falling;
  logic                         rerise;
  logic signed [DATA_WIDTH:0]   x_wide;
  logic signed [DATA_WIDTH:0]   prev_plus;
  logic [WIDTH_BITS-1:0]        width_inc;

  // Re-rise margin is formed one bit wider so prev near full scale cannot wrap.
  always_comb begin
    x_wide    = $signed({x_q[DATA_WIDTH-1], x_q});
    prev_plus = $signed({prev_q[DATA_WIDTH-1], prev_q}) + DeltaW;
    above     = $signed(x_q) > $signed(threshold);
    new_peak  = $signed(x_q) > $signed(peak_q);
    falling   = $signed(x_q) < $signed(prev_q);
    rerise    = x_wide > prev_plus;
    width_inc = (width_q == '1) ? width_q : width_q + WIDTH_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      ts_q           <= '0;
      x_q            <= '0;
      x_ts_q         <= '0;
      x_vld_q        <= 1'b0;
      prev_q         <= '0;
      peak_q         <= '0;
      peak_time_q    <= '0;
      width_q        <= '0;
      pile_q         <= 1'b0;
      hold_q         <= '0;
      output_valid   <= 1'b0;
      peak_amplitude <= '0;
      peak_time      <= '0;
      pulse_width    <= '0;
      pile_up        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      ts_q         <= ts_q + TIME_WIDTH'(1);
      x_q          <= input_data;
      x_ts_q       <= ts_q;
      x_vld_q      <= 1'b1;
      prev_q       <= x_q;
      output_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          // x_vld_q masks the cleared stage register right after reset.
          if (x_vld_q && above) begin
            peak_q      <= x_q;
            peak_time_q <= x_ts_q;
            width_q     <= WIDTH_BITS'(1);
            pile_q      <= 1'b0;
            busy        <= 1'b1;
            state_q     <= StRise;
          end
        end
        StRise, StFall: begin
          if (!above) begin
            output_valid   <= 1'b1;
            peak_amplitude <= peak_q;
            peak_time      <= peak_time_q;
            pulse_width    <= width_q;
            pile_up        <= pile_q;
            hold_q         <= HoldW'(HOLDOFF - 1);
            state_q        <= StHold;
          end else begin
            width_q <= width_inc;
            if (new_peak) begin
              peak_q      <= x_q;
              peak_time_q <= x_ts_q;
            end
            if (state_q == StRise && falling) begin
              state_q <= StFall;
            end
            if (state_q == StFall && rerise) begin
              pile_q  <= 1'b1;
              state_q <= StRise;
            end
          end
        end
        StHold: begin
          if (hold_q == '0) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            hold_q <= hold_q - HoldW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_analyzer.sv
// Bench for pulse_analyzer: directed pulses with literal expectations plus randomized streams
// checked every cycle against a pulse-level reference model.
module tb_pulse_analyzer;

  localparam int DW = 16;
  localparam int TW = 16;
  localparam int WB = 8;
  localparam int HO = 8;
  localparam int PD = 4;
  localparam int Never = 1 << 30;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] input_data = '0;
  logic [DW-1:0] threshold = '0;
  logic          output_valid;
  logic [DW-1:0] peak_amplitude;
  logic [TW-1:0] peak_time;
  logic [WB-1:0] pulse_width;
  logic          pile_up;
  logic          busy;

  always #5 clk = ~clk;

  pulse_analyzer #(
    .DATA_WIDTH  (DW),
    .TIME_WIDTH  (TW),
    .WIDTH_BITS  (WB),
    .HOLDOFF     (HO),
    .PILEUP_DELTA(PD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .input_data    (input_data),
    .threshold     (threshold),
    .output_valid  (output_valid),
    .peak_amplitude(peak_amplitude),
    .peak_time     (peak_time),
    .pulse_width   (pulse_width),
    .pile_up       (pile_up),
    .busy          (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cur_thr  = 100;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model state: cycle index since reset, open pulse samples, expected records.
  bit model_ok = 1'b0;
  int cyc;
  bit run_open;
  int run_start;
  int run_v[$];
  int armed_from;
  int busy_from;
  int busy_until;
  int eq_cyc[$], eq_peak[$], eq_time[$], eq_width[$], eq_pile[$];
  int h_peak, h_time, h_width, h_pile;
  int cap_cyc[$], cap_peak[$], cap_time[$], cap_width[$], cap_pile[$];

  // Pile-up: any rise of more than PD over the previous sample after the pulse first dipped.
  function automatic void analyze(input int vals[$], output int pk, output int ix,
                                  output int wd, output int pl);
    bit dropped;
    pk = vals[0];
    ix = 0;
    pl = 0;
    dropped = 1'b0;
    for (int i = 1; i < vals.size(); i++) begin
      if (vals[i] > pk) begin
        pk = vals[i];
        ix = i;
      end
      if (dropped && vals[i] > vals[i-1] + PD) pl = 1;
      if (vals[i] < vals[i-1]) dropped = 1'b1;
    end
    wd = (vals.size() > 255) ? 255 : vals.size();
  endfunction

  always @(negedge clk) begin : compare
    int v, t, pk, ix, wd, pl;
    bit ev, eb;
    if (model_ok) begin
      ev = (eq_cyc.size() > 0) && (eq_cyc[0] == cyc);
      if (ev) begin
        void'(eq_cyc.pop_front());
        h_peak  = eq_peak.pop_front();
        h_time  = eq_time.pop_front();
        h_width = eq_width.pop_front();
        h_pile  = eq_pile.pop_front();
      end
      eb = (cyc >= busy_from) && (cyc <= busy_until);
      n_checks++;
      if (output_valid == ev && int'($signed(peak_amplitude)) == h_peak &&
          int'(peak_time) == h_time && int'(pulse_width) == h_width &&
          int'(pile_up) == h_pile && busy == eb) begin
        n_pass++;
      end else begin
        $display("FAIL cycle %0d (got/expected): valid=%0b/%0b peak=%0d/%0d time=%0d/%0d width=%0d/%0d pile=%0b/%0b busy=%0b/%0b",
                 cyc, output_valid, ev, $signed(peak_amplitude), h_peak, peak_time, h_time,
                 pulse_width, h_width, pile_up, h_pile, busy, eb);
      end
      if (output_valid === 1'b1) begin
        cap_cyc.push_back(cyc);
        cap_peak.push_back(int'($signed(peak_amplitude)));
        cap_time.push_back(int'(peak_time));
        cap_width.push_back(int'(pulse_width));
        cap_pile.push_back(int'(pile_up));
      end
    end
    if (reset) begin
      model_ok   = 1'b1;
      cyc        = 0;
      run_open   = 1'b0;
      run_v.delete();
      armed_from = 0;
      busy_from  = Never;
      busy_until = -1;
      eq_cyc.delete(); eq_peak.delete(); eq_time.delete(); eq_width.delete(); eq_pile.delete();
      h_peak = 0; h_time = 0; h_width = 0; h_pile = 0;
    end else if (model_ok) begin
      v = int'($signed(input_data));
      t = int'($signed(threshold));
      if (!run_open) begin
        if (cyc >= armed_from && v > t) begin
          run_open   = 1'b1;
          run_start  = cyc;
          run_v      = '{v};
          busy_from  = cyc + 2;
          busy_until = Never;
        end
      end else if (v > t) begin
        run_v.push_back(v);
      end else begin
        analyze(run_v, pk, ix, wd, pl);
        eq_cyc.push_back(cyc + 2);
        eq_peak.push_back(pk);
        eq_time.push_back((run_start + ix) & 32'hFFFF);
        eq_width.push_back(wd);
        eq_pile.push_back(pl);
        armed_from = cyc + HO + 1;
        busy_until = cyc + HO + 1;
        run_open   = 1'b0;
      end
      cyc++;
    end
  end

  task automatic step(input int v, input bit rst);
    @(posedge clk);
    #1;
    reset      = rst;
    input_data = DW'(v);
    threshold  = DW'(cur_thr);
  endtask

  task automatic clear_cap();
    cap_cyc.delete(); cap_peak.delete(); cap_time.delete(); cap_width.delete(); cap_pile.delete();
  endtask

  task automatic run_seq(input int vals[$], input int idle_v, input int idle_n);
    foreach (vals[i]) step(vals[i], 1'b0);
    repeat (idle_n) step(idle_v, 1'b0);
  endtask

  task automatic check_rec(input string name, input int c, input int pk, input int tm,
                           input int wd, input int pl);
    chk({name, " count"}, cap_cyc.size(), 1);
    if (cap_cyc.size() > 0) begin
      chk({name, " cycle"}, cap_cyc[0], c);
      chk({name, " peak"}, cap_peak[0], pk);
      chk({name, " time"}, cap_time[0], tm);
      chk({name, " width"}, cap_width[0], wd);
      chk({name, " pile"}, cap_pile[0], pl);
    end
  endtask

  task automatic check_zero(input string name);
    @(negedge clk);
    #1;
    chk({name, " valid"}, int'(output_valid), 0);
    chk({name, " busy"}, int'(busy), 0);
    chk({name, " peak"}, int'(peak_amplitude), 0);
    chk({name, " time"}, int'(peak_time), 0);
    chk({name, " width"}, int'(pulse_width), 0);
    chk({name, " pile"}, int'(pile_up), 0);
  endtask

  initial begin
    int v, len, mode;
    bit rst;
    int sat[$];

    cur_thr = 100;
    step(0, 1'b1);
    step(0, 1'b1);

    // Single pulse: samples at ts 0..7, record in cycle 8
    clear_cap();
    step(0, 1'b0);
    check_zero("reset state");
    run_seq('{50, 150, 300, 250, 120, 80, 0}, 0, 20);
    check_rec("single", 8, 300, 3, 4, 0);

    // Pile-up and its no-pile variant
    step(0, 1'b1);
    clear_cap();
    run_seq('{0, 150, 300, 200, 260, 120, 50}, 0, 20);
    check_rec("pileup", 8, 300, 2, 5, 1);
    step(0, 1'b1);
    clear_cap();
    run_seq('{0, 150, 300, 200, 203, 120, 50}, 0, 20);
    check_rec("no pileup", 8, 300, 2, 5, 0);

    // Tie keeps earlier sample; second pulse falls inside holdoff
    step(0, 1'b1);
    clear_cap();
    run_seq('{0, 150, 300, 300, 90, 90, 200, 90}, 0, 20);
    check_rec("tie", 6, 300, 2, 3, 0);

    // Reset during the 300 sample; outputs still hold the tie record beforehand
    clear_cap();
    run_seq('{0, 50, 150}, 0, 0);
    step(300, 1'b1);
    step(0, 1'b0);
    check_zero("mid reset");
    repeat (20) step(0, 1'b0);
    chk("mid reset count", cap_cyc.size(), 0);

    // Width saturation
    step(0, 1'b1);
    clear_cap();
    sat.delete();
    sat.push_back(0);
    repeat (300) sat.push_back(500);
    run_seq(sat, 0, 20);
    check_rec("saturate", 303, 500, 1, 255, 0);

    // Negative threshold, pulse straddling the timestamp wrap
    cur_thr = -10;
    step(-50, 1'b1);
    clear_cap();
    repeat (65534) step(-50, 1'b0);
    run_seq('{-5, 20, -5, -50}, -50, 20);
    check_rec("wrap", 65539, 20, 65535, 3, 0);

    // Randomized segments with occasional resets and threshold changes
    cur_thr = 100;
    step(0, 1'b1);
    for (int seg = 0; seg < 150; seg++) begin
      if ($urandom_range(0, 7) == 0) begin
        cur_thr = int'($urandom_range(0, 500)) - 200;
        step(cur_thr - 20, 1'b1);
      end
      len  = int'($urandom_range(1, 25));
      mode = int'($urandom_range(0, 3));
      for (int i = 0; i < len; i++) begin
        case (mode)
          0:       v = cur_thr - int'($urandom_range(0, 150));
          3:       v = 32767 - int'($urandom_range(0, 8));
          default: v = cur_thr + 1 + int'($urandom_range(0, 400));
        endcase
        rst = ($urandom_range(0, 299) == 0);
        step(v, rst);
      end
    end
    repeat (20) step(cur_thr - 50, 1'b0);
    @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
